frame_freeze_sched: RTL
=======================

Name: frame_freeze_sched

Overview:
- Schedules frame-freeze events for the multi-camera VGA path.
- Collects freeze requests from up to N_REQ sources (per-camera ABS event detectors, debounced button) and grants them one at a time in round-robin order.
- Aligns each freeze to frame boundaries, holds it for HOLD_FRAMES active frames, then enforces a COOL_FRAMES cooldown before the next grant.
- Drives the freeze-enable and camera-select that feed the frame-stop/display mux.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_FRAMES, 240, active frames a freeze lasts (>=1).
- COOL_FRAMES, 30, frames of cooldown after a freeze (0 = no cooldown).
- V_ACTIVE, 480, first non-active line; active area is y_pixel < V_ACTIVE.

Ports:
- vga_pclk  in  1  pixel clock.
- reset  in  1  async active-high reset.
- y_pixel  in  10  current VGA line from the sync generator.
- req  in  N_REQ  freeze request pulses, one bit per source.
- abort  in  1  cancel the current freeze or arm (pulse).
- freeze_active  out  1  freeze in effect; display holds its frame.
- freeze_sel  out  $clog2(N_REQ)  index of the granted source; stable while busy.
- grant  out  N_REQ  one-hot, 1-cycle pulse on acceptance.
- done  out  1  1-cycle pulse when a hold completes normally or is aborted.
- busy  out  1  state != IDLE.
- pending  out  N_REQ  sticky queued requests (also drives LEDs).

Behaviour:
- Interface: reset is asynchronous, active-high; clock is vga_pclk.
- Reset values: all outputs 0, state IDLE, pend 0, cnt 0, RR pointer 0, yen_d 1.
- Frame start: yen = y_pixel < V_ACTIVE; yen_d is registered; fs = yen & ~yen_d.
  - fs is a single-cycle pulse on the first active line.
  - No spurious fs after reset, whatever line reset is released on.
- Pending queue:
  - pend <= (pend | req) & ~grant_vec each cycle.
  - A source already pending or currently granted that requests again is queued again; requests are never dropped.
- Round-robin arbitration:
  - Search pend starting at index ptr+1 mod N_REQ.
  - After a grant to index k, ptr <= k.
- States:
  - IDLE: if pend != 0, then grant = onehot(k), freeze_sel <= k, clear pend[k], go to ARM. Latency: req at cycle t, pend at t+1, grant at t+1 with ARM from t+2.
  - ARM: on fs, freeze_active <= 1, cnt <= 0, go to HOLD. On abort, done pulse and go to COOL, or to IDLE if COOL_FRAMES=0.
  - HOLD: on fs, if cnt == HOLD_FRAMES-1 then freeze_active <= 0, done pulse, cnt <= 0 and go to COOL (or IDLE if COOL_FRAMES=0); else cnt++. The freeze therefore covers exactly HOLD_FRAMES full active frames. On abort, freeze_active <= 0 the next cycle, done pulse, then the same exit path.
  - COOL: on fs, if cnt == COOL_FRAMES-1 then go to IDLE; else cnt++.
- Simultaneous events:
  - abort and fs in the same cycle: abort wins.
  - req arriving in any state is queued.
  - abort in IDLE or COOL is ignored.
- cnt width: $clog2(max(HOLD_FRAMES, COOL_FRAMES)+1), unsigned, with no wrap; terminal compare only.
- freeze_active, grant and done are registered outputs, with no combinational path from inputs.
- Reset mid-HOLD: everything returns to reset values immediately; pending requests are lost.

Decomposition:
- Package frame_freeze_pkg:
  - state enum {IDLE, ARM, HOLD, COOL}.
  - V_ACTIVE=480, H_ACTIVE=640.
  - Shared function onehot().
- Sub-module rr_arbiter (N parameter):
  - Inputs: pend, ptr.
  - Outputs: grant_vec, idx, any.
  - Combinational; ptr register kept in the parent.

Test Plan:
- Use HOLD_FRAMES=4, COOL_FRAMES=2, N_REQ=4, with a y_pixel model of 0..524 per frame.
- Single request: req=0001 mid-frame → grant=0001 two cycles later. freeze_active rises one cycle after the next fs and stays high for exactly 4 fs edges. done pulses with the falling edge. busy stays high for a further 2 frames.
- Contention: req=1010 in one cycle with ptr=0 → grant 0010 first, then 1000 after the first cooldown, then idle. freeze_sel shows 1, then 3.
- Re-request while busy: source 2 requests during its own HOLD → pending[2]=1. It is re-granted after COOL, giving a second 4-frame freeze.
- Abort during HOLD after 2 frames: freeze_active drops the next cycle, done=1, COOL runs for 2 frames. Abort in IDLE has no effect.
- Abort coincident with fs in ARM: no freeze_active pulse at all; state goes to COOL.
- Async reset asserted mid-HOLD with pend=0100: all outputs are 0 during reset. After release there is no grant, and no fs until the next true blank-to-active transition.

Source files
------------

// File: rtl/frame_freeze_sched_pkg.sv
// Shared types and constants for the frame-freeze scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_freeze_pkg;

  typedef enum logic [1:0] {IDLE, ARM, HOLD, COOL} state_t;

  localparam int V_ACTIVE = 480;
  localparam int H_ACTIVE = 640;
  localparam int MAX_REQ  = 8;

  // One-hot decode sized for the largest supported requester count;
  // callers truncate to their own width.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/frame_freeze_sched_if.sv
// Request/status bundle between freeze sources and the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; requests are pulses queued inside the scheduler.
// Ports: req/abort from sources; freeze_active, freeze_sel, grant, done,
// busy, pending back from the scheduler.
interface frame_freeze_sched_if #(
  parameter int N_REQ = 4
);
  localparam int SEL_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             abort;
  logic             freeze_active;
  logic [SEL_W-1:0] freeze_sel;
  logic [N_REQ-1:0] grant;
  logic             done;
  logic             busy;
  logic [N_REQ-1:0] pending;

  modport master (
    output req, abort,
    input  freeze_active, freeze_sel, grant, done, busy, pending
  );

  modport slave (
    input  req, abort,
    output freeze_active, freeze_sel, grant, done, busy, pending
  );
endinterface

// File: rtl/frame_freeze_sched_rr_arbiter.sv
// Round-robin pick over pending requests, searching from ptr+1 upward.
// Latency: combinational.
// Backpressure: none; the parent decides whether to take the pick.
// Ports: pend/ptr in; grant_vec (one-hot), idx, any out.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pend,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  import frame_freeze_pkg::*;

  localparam int IW = $clog2(N);

  logic [IW-1:0] j;

  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    // Walk ptr+1, ptr+2, ... ptr (wrapping); the first set bit wins.
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!any && pend[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
    grant_vec = any ? N'(onehot(3'(idx))) : '0;
  end

endmodule

// File: rtl/frame_freeze_sched.sv
// Grants freeze requests one at a time (round-robin), aligns each freeze to
// frame starts, holds HOLD_FRAMES active frames, then cools COOL_FRAMES frames.
// Latency: req -> grant 2 cycles; freeze_active rises 1 cycle after frame start.
// Backpressure: none; requests queue as sticky pending bits and are never refused.
// Ports: vga_pclk, reset (async, active-high), y_pixel, bus (slave side).
module frame_freeze_sched #(
  parameter int N_REQ       = 4,
  parameter int HOLD_FRAMES = 240,
  parameter int COOL_FRAMES = 30,
  parameter int V_ACTIVE    = 480
) (
  input  logic       vga_pclk,
  input  logic       reset,
  input  logic [9:0] y_pixel,
  frame_freeze_sched_if.slave bus
);
  import frame_freeze_pkg::*;

  localparam int SEL_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (HOLD_FRAMES > COOL_FRAMES) ? HOLD_FRAMES : COOL_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'((COOL_FRAMES > 0) ? COOL_FRAMES - 1 : 0);
  // With no cooldown a finished or aborted freeze drops straight to IDLE.
  localparam state_t EXIT_ST = (COOL_FRAMES == 0) ? IDLE : COOL;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [N_REQ-1:0] pend, arb_vec, grant_nxt, grant_r;
  logic [SEL_W-1:0] ptr, arb_idx, sel_r;
  logic             arb_any, take;
  logic             fa_r, fa_nxt, done_r, done_nxt;
  logic             yen, yen_d, fs;

  // yen_d resets to 1 so releasing reset inside the active area cannot
  // look like a blank-to-active transition.
  assign yen = (y_pixel < 10'(V_ACTIVE));
  assign fs  = yen & ~yen_d;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .pend      (pend),
    .ptr       (ptr),
    .grant_vec (arb_vec),
    .idx       (arb_idx),
    .any       (arb_any)
  );

  assign take      = (state == IDLE) && arb_any;
  assign grant_nxt = take ? arb_vec : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fa_nxt    = fa_r;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: if (take) state_nxt = ARM;
      ARM: begin
        // abort outranks a coincident frame start: the freeze never shows.
        if (bus.abort) begin
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = EXIT_ST;
        end else if (fs) begin
          fa_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.abort || (fs && cnt == HOLD_LAST)) begin
          fa_nxt    = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = EXIT_ST;
        end else if (fs) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      COOL: begin
        if (fs) begin
          if (cnt == COOL_LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_pclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      ptr     <= '0;
      sel_r   <= '0;
      grant_r <= '0;
      fa_r    <= 1'b0;
      done_r  <= 1'b0;
      yen_d   <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= (pend | bus.req) & ~grant_nxt;
      grant_r <= grant_nxt;
      fa_r    <= fa_nxt;
      done_r  <= done_nxt;
      yen_d   <= yen;
      if (take) begin
        sel_r <= arb_idx;
        ptr   <= arb_idx;
      end
    end
  end

  assign bus.freeze_active = fa_r;
  assign bus.freeze_sel    = sel_r;
  assign bus.grant         = grant_r;
  assign bus.done          = done_r;
  assign bus.busy          = (state != IDLE);
  assign bus.pending       = pend;

endmodule
